// File: rtl/register_writeback_queue.sv
// Register write-back queue: in-order buffer between multi-cycle producers
// and the register bank write port, with bypass lookup and a pending bitmap.
module register_writeback_queue #(
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [4:0]    req_address,
    input  logic [31:0]   req_data,
    input  logic          hold,
    output logic          bank_write,
    output logic [4:0]    bank_write_address,
    output logic [31:0]   bank_write_data,
    input  logic [4:0]    lookup_address_1,
    input  logic [4:0]    lookup_address_2,
    output logic          lookup_hit_1,
    output logic          lookup_hit_2,
    output logic [31:0]   lookup_data_1,
    output logic [31:0]   lookup_data_2,
    output logic [31:0]   pending,
    output logic [CW-1:0] count
);

    localparam int            AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wb_entry_t;

    wb_entry_t     mem [DEPTH];
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [CW-1:0] count_q;
    logic          push;
    logic          pop;

    assign count     = count_q;
    // Full blocks acceptance even when a pop frees a slot at the same edge.
    assign req_ready = !reset && (count_q < DEPTH_C);
    // Writes to r0 complete the handshake but are dropped here.
    assign push      = req_valid && req_ready && (req_address != 5'd0);
    assign pop       = !hold && (count_q != '0);

    // Entry storage; no reset needed since occupancy is tracked by count.
    always_ff @(posedge clk) begin
        if (push) mem[tail] <= '{addr: req_address, data: req_data};
    end

    // Pointers, occupancy and the registered bank write port.
    always_ff @(posedge clk) begin
        if (reset) begin
            head               <= '0;
            tail               <= '0;
            count_q            <= '0;
            bank_write         <= 1'b0;
            bank_write_address <= '0;
            bank_write_data    <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop) begin
                head               <= head + 1'b1;
                bank_write         <= 1'b1;
                bank_write_address <= mem[head].addr;
                bank_write_data    <= mem[head].data;
            end else begin
                bank_write <= 1'b0;
            end
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    // Bypass search oldest-to-newest so later matches overwrite earlier ones;
    // the presented entry is older than anything still queued.
    always_comb begin
        logic [AW-1:0] idx;
        idx           = '0;
        lookup_hit_1  = 1'b0;
        lookup_hit_2  = 1'b0;
        lookup_data_1 = '0;
        lookup_data_2 = '0;
        pending       = '0;
        if (bank_write) begin
            pending[bank_write_address] = 1'b1;
            if (bank_write_address == lookup_address_1) begin
                lookup_hit_1  = 1'b1;
                lookup_data_1 = bank_write_data;
            end
            if (bank_write_address == lookup_address_2) begin
                lookup_hit_2  = 1'b1;
                lookup_data_2 = bank_write_data;
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + AW'(i);
            if (CW'(i) < count_q) begin
                pending[mem[idx].addr] = 1'b1;
                if (mem[idx].addr == lookup_address_1) begin
                    lookup_hit_1  = 1'b1;
                    lookup_data_1 = mem[idx].data;
                end
                if (mem[idx].addr == lookup_address_2) begin
                    lookup_hit_2  = 1'b1;
                    lookup_data_2 = mem[idx].data;
                end
            end
        end
        if (lookup_address_1 == 5'd0) begin
            lookup_hit_1  = 1'b0;
            lookup_data_1 = '0;
        end
        if (lookup_address_2 == 5'd0) begin
            lookup_hit_2  = 1'b0;
            lookup_data_2 = '0;
        end
        pending[0] = 1'b0;
    end

endmodule

// File: tb/tb_register_writeback_queue.sv
// Bench for register_writeback_queue: directed scenarios plus randomized
// traffic against a queue-based reference model.
module tb_register_writeback_queue;
    localparam int DEPTH = 4;
    localparam int CW    = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [4:0]    req_address = '0;
    logic [31:0]   req_data = '0;
    logic          hold = 1'b0;
    logic          bank_write;
    logic [4:0]    bank_write_address;
    logic [31:0]   bank_write_data;
    logic [4:0]    lookup_address_1 = '0;
    logic [4:0]    lookup_address_2 = '0;
    logic          lookup_hit_1, lookup_hit_2;
    logic [31:0]   lookup_data_1, lookup_data_2;
    logic [31:0]   pending;
    logic [CW-1:0] count;

    always #5 clk = ~clk;

    register_writeback_queue #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_address(req_address), .req_data(req_data), .hold(hold),
        .bank_write(bank_write), .bank_write_address(bank_write_address),
        .bank_write_data(bank_write_data),
        .lookup_address_1(lookup_address_1), .lookup_address_2(lookup_address_2),
        .lookup_hit_1(lookup_hit_1), .lookup_hit_2(lookup_hit_2),
        .lookup_data_1(lookup_data_1), .lookup_data_2(lookup_data_2),
        .pending(pending), .count(count)
    );

    // Reference model: queued writes in order, plus the presented write.
    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;
    ent_t        q[$];
    logic        m_bw = 1'b0;
    logic [4:0]  m_ba = '0;
    logic [31:0] m_bd = '0;

    int n_chk  = 0;
    int n_pass = 0;

    function automatic logic [31:0] m_pending();
        logic [31:0] p;
        p = '0;
        if (m_bw) p[m_ba] = 1'b1;
        foreach (q[i]) p[q[i].a] = 1'b1;
        p[0] = 1'b0;
        return p;
    endfunction

    // Newest-first search: last queued, then the presented entry.
    function automatic void m_lookup(input logic [4:0] la, output logic hit, output logic [31:0] d);
        hit = 1'b0;
        d   = '0;
        if (la == 5'd0) return;
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].a == la) begin
                hit = 1'b1;
                d   = q[i].d;
                return;
            end
        end
        if (m_bw && m_ba == la) begin
            hit = 1'b1;
            d   = m_bd;
        end
    endfunction

    // Drive one cycle, advance the model across the edge, settle 1 time unit.
    task automatic step(input logic v, input logic [4:0] a, input logic [31:0] d,
                        input logic h, input logic r);
        logic acc;
        ent_t e;
        req_valid = v; req_address = a; req_data = d; hold = h; reset = r;
        #1;
        acc = v && !r && (q.size() < DEPTH);
        @(posedge clk);
        if (r) begin
            q.delete();
            m_bw = 1'b0; m_ba = '0; m_bd = '0;
        end else begin
            if (!h && q.size() > 0) begin
                e = q.pop_front();
                m_bw = 1'b1; m_ba = e.a; m_bd = e.d;
            end else begin
                m_bw = 1'b0;
            end
            if (acc && a != 5'd0) q.push_back('{a: a, d: d});
        end
        #1;
    endtask

    task automatic test_reset();
        step(1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
        step(1'b1, 5'd3, 32'h5, 1'b0, 1'b1);
        n_chk++; if (bank_write !== 1'b0) $display("FAIL reset_bw got %0b exp 0", bank_write); else n_pass++;
        n_chk++; if (count !== 3'd0) $display("FAIL reset_count got %0d exp 0", count); else n_pass++;
        n_chk++; if (pending !== 32'd0) $display("FAIL reset_pending got %h exp 0", pending); else n_pass++;
        n_chk++; if (bank_write_address !== 5'd0 || bank_write_data !== 32'd0)
            $display("FAIL reset_bank got %0d/%h exp 0/0", bank_write_address, bank_write_data); else n_pass++;
        n_chk++; if (req_ready !== 1'b0) $display("FAIL reset_ready_in_reset got %0b exp 0", req_ready); else n_pass++;
        step(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        n_chk++; if (req_ready !== 1'b1) $display("FAIL reset_ready_after got %0b exp 1", req_ready); else n_pass++;
    endtask

    task automatic test_single();
        step(1'b1, 5'd5, 32'h11111111, 1'b0, 1'b0);
        n_chk++; if (bank_write !== 1'b0 || count !== 3'd1 || pending[5] !== 1'b1)
            $display("FAIL single_accept got bw=%0b cnt=%0d p5=%0b exp 0/1/1", bank_write, count, pending[5]); else n_pass++;
        step(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        n_chk++; if (bank_write !== 1'b1 || bank_write_address !== 5'd5 || bank_write_data !== 32'h11111111)
            $display("FAIL single_present got %0b/%0d/%h exp 1/5/11111111", bank_write, bank_write_address, bank_write_data); else n_pass++;
        n_chk++; if (count !== 3'd0 || pending !== 32'h20)
            $display("FAIL single_pending got cnt=%0d p=%h exp 0/00000020", count, pending); else n_pass++;
        step(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        n_chk++; if (bank_write !== 1'b0 || pending !== 32'd0 || bank_write_address !== 5'd5)
            $display("FAIL single_after got bw=%0b p=%h a=%0d exp 0/0/5", bank_write, pending, bank_write_address); else n_pass++;
    endtask

    task automatic test_hold_fill();
        for (int i = 1; i <= 4; i++) step(1'b1, 5'(i), $urandom, 1'b1, 1'b0);
        n_chk++; if (req_ready !== 1'b0 || count !== 3'd4)
            $display("FAIL full_state got rdy=%0b cnt=%0d exp 0/4", req_ready, count); else n_pass++;
        // Full with a pop at the same edge: request must still be refused.
        step(1'b1, 5'd9, 32'h99, 1'b0, 1'b0);
        n_chk++; if (count !== 3'd3 || bank_write !== 1'b1 || bank_write_address !== 5'd1)
            $display("FAIL full_pop got cnt=%0d bw=%0b a=%0d exp 3/1/1", count, bank_write, bank_write_address); else n_pass++;
        for (int k = 2; k <= 4; k++) begin
            step(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
            n_chk++; if (bank_write !== 1'b1 || bank_write_address !== 5'(k) || bank_write_data !== m_bd)
                $display("FAIL drain_order got %0b/%0d/%h exp 1/%0d/%h", bank_write, bank_write_address, bank_write_data, k, m_bd); else n_pass++;
        end
        n_chk++; if (req_ready !== 1'b1 || count !== 3'd0)
            $display("FAIL drain_ready got rdy=%0b cnt=%0d exp 1/0", req_ready, count); else n_pass++;
        step(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        n_chk++; if (bank_write !== 1'b0) $display("FAIL drain_end got bw=%0b exp 0", bank_write); else n_pass++;
    endtask

    task automatic test_dup();
        step(1'b1, 5'd7, 32'hA, 1'b1, 1'b0);
        step(1'b1, 5'd7, 32'hB, 1'b1, 1'b0);
        lookup_address_1 = 5'd7;
        #1;
        n_chk++; if (lookup_hit_1 !== 1'b1 || lookup_data_1 !== 32'hB)
            $display("FAIL dup_lookup got %0b/%h exp 1/0000000b", lookup_hit_1, lookup_data_1); else n_pass++;
        step(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        n_chk++; if (bank_write_data !== 32'hA || lookup_data_1 !== 32'hB)
            $display("FAIL dup_first got bank=%h lk=%h exp a/b", bank_write_data, lookup_data_1); else n_pass++;
        step(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        n_chk++; if (bank_write !== 1'b1 || bank_write_data !== 32'hB || lookup_data_1 !== 32'hB)
            $display("FAIL dup_second got bw=%0b bank=%h lk=%h exp 1/b/b", bank_write, bank_write_data, lookup_data_1); else n_pass++;
        step(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        n_chk++; if (pending[7] !== 1'b0 || lookup_hit_1 !== 1'b0 || lookup_data_1 !== 32'd0)
            $display("FAIL dup_cleared got p7=%0b hit=%0b d=%h exp 0/0/0", pending[7], lookup_hit_1, lookup_data_1); else n_pass++;
        lookup_address_1 = 5'd0;
    endtask

    task automatic test_r0();
        req_valid = 1'b1; req_address = 5'd0; req_data = 32'hFFFFFFFF; hold = 1'b0; reset = 1'b0;
        #1;
        n_chk++; if (req_ready !== 1'b1) $display("FAIL r0_ready got %0b exp 1", req_ready); else n_pass++;
        step(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 1'b0);
        lookup_address_2 = 5'd0;
        #1;
        n_chk++; if (count !== 3'd0 || pending !== 32'd0)
            $display("FAIL r0_count got cnt=%0d p=%h exp 0/0", count, pending); else n_pass++;
        n_chk++; if (lookup_hit_2 !== 1'b0 || lookup_data_2 !== 32'd0)
            $display("FAIL r0_lookup got %0b/%h exp 0/0", lookup_hit_2, lookup_data_2); else n_pass++;
        step(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        n_chk++; if (bank_write !== 1'b0) $display("FAIL r0_nowrite got %0b exp 0", bank_write); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] dv [11];
        for (int i = 1; i <= 10; i++) dv[i] = $urandom;
        for (int i = 1; i <= 10; i++) begin
            step(1'b1, 5'(i), dv[i], 1'b0, 1'b0);
            n_chk++; if (count > 3'd1) $display("FAIL stream_count got %0d exp <=1", count); else n_pass++;
            if (i >= 2) begin
                n_chk++; if (bank_write !== 1'b1 || bank_write_address !== 5'(i - 1) || bank_write_data !== dv[i - 1])
                    $display("FAIL stream_write got %0b/%0d/%h exp 1/%0d/%h", bank_write, bank_write_address, bank_write_data, i - 1, dv[i - 1]); else n_pass++;
            end
        end
        step(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        n_chk++; if (bank_write !== 1'b1 || bank_write_address !== 5'd10 || bank_write_data !== dv[10])
            $display("FAIL stream_last got %0b/%0d/%h exp 1/10/%h", bank_write, bank_write_address, bank_write_data, dv[10]); else n_pass++;
        step(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        for (int i = 1; i <= 4; i++) step(1'b1, 5'(i + 10), $urandom, 1'b1, 1'b0);
        step(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        n_chk++; if (bank_write !== 1'b1 || count !== 3'd3)
            $display("FAIL mid_setup got bw=%0b cnt=%0d exp 1/3", bank_write, count); else n_pass++;
        step(1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
        n_chk++; if (bank_write !== 1'b0 || count !== 3'd0 || pending !== 32'd0)
            $display("FAIL mid_reset got bw=%0b cnt=%0d p=%h exp 0/0/0", bank_write, count, pending); else n_pass++;
        step(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        n_chk++; if (req_ready !== 1'b1 || bank_write !== 1'b0)
            $display("FAIL mid_after got rdy=%0b bw=%0b exp 1/0", req_ready, bank_write); else n_pass++;
    endtask

    task automatic test_random();
        logic        eh1, eh2;
        logic [31:0] ed1, ed2;
        for (int c = 0; c < 400; c++) begin
            step(($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), $urandom,
                 ($urandom_range(0, 2) == 0), ($urandom_range(0, 39) == 0));
            lookup_address_1 = 5'($urandom_range(0, 7));
            lookup_address_2 = 5'($urandom_range(0, 7));
            #1;
            m_lookup(lookup_address_1, eh1, ed1);
            m_lookup(lookup_address_2, eh2, ed2);
            n_chk++; if (bank_write !== m_bw || bank_write_address !== m_ba || bank_write_data !== m_bd)
                $display("FAIL rnd_bank c=%0d got %0b/%0d/%h exp %0b/%0d/%h", c, bank_write, bank_write_address, bank_write_data, m_bw, m_ba, m_bd); else n_pass++;
            n_chk++; if (count !== CW'(q.size()) || req_ready !== (!reset && q.size() < DEPTH))
                $display("FAIL rnd_count c=%0d got cnt=%0d rdy=%0b exp %0d", c, count, req_ready, q.size()); else n_pass++;
            n_chk++; if (pending !== m_pending())
                $display("FAIL rnd_pending c=%0d got %h exp %h", c, pending, m_pending()); else n_pass++;
            n_chk++; if (lookup_hit_1 !== eh1 || lookup_data_1 !== ed1)
                $display("FAIL rnd_lookup1 c=%0d got %0b/%h exp %0b/%h", c, lookup_hit_1, lookup_data_1, eh1, ed1); else n_pass++;
            n_chk++; if (lookup_hit_2 !== eh2 || lookup_data_2 !== ed2)
                $display("FAIL rnd_lookup2 c=%0d got %0b/%h exp %0b/%h", c, lookup_hit_2, lookup_data_2, eh2, ed2); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_hold_fill();
        test_dup();
        test_r0();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    // Stimulus is purely clock-paced; this only guards against a stalled clock.
    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end
endmodule

// File: doc/register_writeback_queue.md
Name: register_writeback_queue

Overview:
- Initiator side of the register bank write port.
- Buffers register write requests from multi-cycle producers (load unit, mult/div) in an in-order FIFO.
- Drains the FIFO to the register bank at one write per cycle.
- Exposes a newest-wins bypass lookup and a pending-register bitmap, so decode can forward or stall on registers whose writes have not yet reached the bank.

Parameters:
DEPTH, 4, number of queue entries; power of two, minimum 2.
CW, 3, width of count output; equals log2(DEPTH)+1.

Ports:
clk  input  1  clock; all state changes on posedge clk.
reset  input  1  synchronous, active-high reset.
req_valid  input  1  producer has a write request.
req_ready  output  1  queue can accept a request this cycle.
req_address  input  5  destination register.
req_data  input  32  value to write.
hold  input  1  bank port unavailable; suspends draining.
bank_write  output  1  write strobe to register bank.
bank_write_address  output  5  register bank write address.
bank_write_data  output  32  register bank write data.
lookup_address_1  input  5  bypass query 1.
lookup_address_2  input  5  bypass query 2.
lookup_hit_1  output  1  query 1 matches a pending write.
lookup_hit_2  output  1  query 2 matches a pending write.
lookup_data_1  output  32  newest pending value for query 1; 0 on miss.
lookup_data_2  output  32  newest pending value for query 2; 0 on miss.
pending  output  32  bit i set while any write to register i is queued or presented.
count  output  CW  number of queued entries, excluding the presented entry.

Behaviour:
- Reset (synchronous, at posedge clk with reset=1):
  - head/tail pointers and count cleared; queue empty.
  - bank_write=0, bank_write_address=0, bank_write_data=0.
  - Reset mid-drain discards all queued and presented writes; no bank_write follows.
- req_ready:
  - Combinational, equal to !reset && (count < DEPTH).
  - No accept while full, even if a pop happens in the same cycle.
- Handshake: a transfer occurs at posedge when req_valid && req_ready.
- Register 0:
  - A transfer with req_address==0 completes but is not enqueued.
  - count and pending are unchanged by it.
- Enqueue: entry written at tail, tail increments modulo DEPTH, count+1.
- Drain (the bank_write_* outputs are registers):
  - At each posedge with hold==0 and count>0, the head entry is popped into bank_write_address/bank_write_data, bank_write<=1, head increments modulo DEPTH, count-1.
  - Otherwise bank_write<=0; address and data hold their last values.
  - Outputs are stable for a full cycle, so the bank's negedge write samples them mid-cycle.
- Latency:
  - A request accepted at edge N into an empty queue is presented at edge N+1 (bank_write high from N+1 to N+2).
  - Back-to-back entries are presented on consecutive cycles; peak throughput is one write per cycle.
- Simultaneous enqueue and pop at one edge: both take effect, count unchanged.
- hold:
  - Checked only at posedge.
  - hold=1 blocks popping; enqueue continues.
  - An already-presented write is not re-issued.
- Presented entry: counts as pending only during the cycle in which bank_write=1.
- Lookup (combinational):
  - Searches the presented entry (if bank_write=1) plus all queued entries.
  - On multiple matches, returns the most recently enqueued entry; a queued entry is newer than the presented one.
  - Lookup address 0 always misses with data 0.
  - A request being accepted in the current cycle is not visible until after its edge.
- pending: OR over the presented entry and all queued entries of a one-hot decode of each address; bit 0 is always 0.
- Ordering: strict FIFO; duplicate addresses are kept and written in order, so the bank ends with the newest value.

Test Plan:
- Reset, then accept (r5, 0x11111111) at edge N → bank_write=1, addr=5, data=0x11111111 during cycle N+1 only; pending[5]=1 from N until the end of cycle N+1; count returns to 0.
- hold=1, enqueue r1..r4 (DEPTH=4) → req_ready=0, count=4; release hold → four consecutive bank writes r1,r2,r3,r4, then req_ready=1.
- Enqueue r7=0xA then r7=0xB with hold=1 → lookup_address_1=7 gives hit=1, data=0xB; after drain the bank sees 0xA then 0xB, pending[7]=0.
- Request with req_address=0 and data 0xFFFFFFFF → req_ready=1, count stays 0, no bank_write, lookup_address_2=0 gives hit=0, data=0.
- Continuous one-per-cycle requests r1..r10 with hold=0 → count never exceeds 1, ten consecutive bank writes in order, pointers wrap without loss.
- Assert reset with 3 entries queued and one presented → next cycle bank_write=0, count=0, pending=0, req_ready=1 after reset deasserts.
